// File: rtl/tc_ps_gp_rd_bank.sv
// AXI3 read-slave register bank on PS GP0: serves NREG 32-bit status words, INCR/FIXED bursts up to 16 beats.
// Latency: AR accepted at edge T gives first R beat valid from T+1; back-to-back beats with rready held high.
// Backpressure: rready low holds the R beat stable; arready is low for the whole burst (one outstanding burst).
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   reg_in            flattened status words, word i = reg_in[32*i +: 32]
//   rd_pulse          one-cycle strobe per word, high on the R handshake of a beat that read that word
//   M_AXI_GP0_0_ar*   AXI3 read address channel (cache/lock/prot/qos/size unused)
//   M_AXI_GP0_0_r*    AXI3 read data channel
// Optional feature: define TC_GP_RD_SLVERR_EN to return SLVERR on out-of-range beats.
module tc_ps_gp_rd_bank #(
    parameter int          NREG      = 64,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          ID_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREG*32-1:0]   reg_in,
    output logic [NREG-1:0]      rd_pulse,
    input  logic [31:0]          M_AXI_GP0_0_araddr,
    input  logic [1:0]           M_AXI_GP0_0_arburst,
    input  logic [3:0]           M_AXI_GP0_0_arlen,
    input  logic [2:0]           M_AXI_GP0_0_arsize,
    input  logic [ID_W-1:0]      M_AXI_GP0_0_arid,
    input  logic [3:0]           M_AXI_GP0_0_arcache,
    input  logic [1:0]           M_AXI_GP0_0_arlock,
    input  logic [2:0]           M_AXI_GP0_0_arprot,
    input  logic [3:0]           M_AXI_GP0_0_arqos,
    input  logic                 M_AXI_GP0_0_arvalid,
    output logic                 M_AXI_GP0_0_arready,
    output logic [31:0]          M_AXI_GP0_0_rdata,
    output logic [ID_W-1:0]      M_AXI_GP0_0_rid,
    output logic [1:0]           M_AXI_GP0_0_rresp,
    output logic                 M_AXI_GP0_0_rlast,
    output logic                 M_AXI_GP0_0_rvalid,
    input  logic                 M_AXI_GP0_0_rready
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef TC_GP_RD_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state_q, state_d;
    logic [29:0] cur_idx;     // word index of the beat currently in the R register
    logic [3:0]  cnt;         // beats remaining after the current one
    logic        fixed_q;     // FIXED burst: index does not advance

    logic [31:0] words [NREG];
    logic [31:0] ar_off;
    logic [29:0] ar_idx, nxt_idx, load_idx;
    logic        load_inr, cur_inr;
    logic [31:0] load_word;
    logic        ar_hs, r_hs, load;

    for (genvar g = 0; g < NREG; g++) begin : g_word
        assign words[g] = reg_in[32*g +: 32];
    end

    // Offset from the bank base; a byte address below BASE wraps to a huge
    // index and therefore lands in the out-of-range case naturally.
    assign ar_off = M_AXI_GP0_0_araddr - BASE_ADDR;
    assign ar_idx = ar_off[31:2];

    logic unused_ok;
    assign unused_ok = ^{M_AXI_GP0_0_arsize, M_AXI_GP0_0_arcache, M_AXI_GP0_0_arlock,
                         M_AXI_GP0_0_arprot, M_AXI_GP0_0_arqos, ar_off[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        M_AXI_GP0_0_arready = (state_q == IDLE) && rst;
        M_AXI_GP0_0_rvalid  = (state_q == BURST);
        M_AXI_GP0_0_rlast   = (state_q == BURST) && (cnt == 4'd0);
        ar_hs               = M_AXI_GP0_0_arvalid && M_AXI_GP0_0_arready;
        r_hs                = M_AXI_GP0_0_rvalid && M_AXI_GP0_0_rready;
        nxt_idx             = fixed_q ? cur_idx : cur_idx + 30'd1;
        // A new beat enters the R register on AR acceptance or on any non-last handshake.
        load                = ar_hs || (r_hs && cnt != 4'd0);
        load_idx            = (state_q == IDLE) ? ar_idx : nxt_idx;
        load_inr            = load_idx < 30'(NREG);
        load_word           = load_inr ? words[load_idx[IW-1:0]] : 32'd0;
        cur_inr             = cur_idx < 30'(NREG);
        rd_pulse            = '0;
        if (r_hs && cur_inr) rd_pulse[cur_idx[IW-1:0]] = 1'b1;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_hs && cnt == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            M_AXI_GP0_0_rdata <= '0;
            M_AXI_GP0_0_rid   <= '0;
            M_AXI_GP0_0_rresp <= 2'b00;
            cur_idx           <= '0;
            cnt               <= '0;
            fixed_q           <= 1'b0;
        end else begin
            if (ar_hs) begin
                M_AXI_GP0_0_rid <= M_AXI_GP0_0_arid;
                cnt             <= M_AXI_GP0_0_arlen;
                fixed_q         <= (M_AXI_GP0_0_arburst == 2'b00);
            end else if (r_hs && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (load) begin
                cur_idx           <= load_idx;
                M_AXI_GP0_0_rdata <= load_word;
                M_AXI_GP0_0_rresp <= load_inr ? 2'b00 : OOR_RESP;
            end
        end
    end

endmodule

// File: tb/tb_tc_ps_gp_rd_bank.sv
module tb_tc_ps_gp_rd_bank;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef TC_GP_RD_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2047:0] reg_in = '0;
    logic [63:0]   rd_pulse;
    logic [31:0]   araddr = '0;
    logic [1:0]    arburst = 2'b01;
    logic [3:0]    arlen = '0;
    logic [11:0]   arid = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [11:0]   rid;
    logic [1:0]    rresp;
    logic          rlast, rvalid;
    logic          rready = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulse4_seen = 0;

    always #5 clk = ~clk;

    tc_ps_gp_rd_bank dut (
        .clk(clk), .rst(rst), .reg_in(reg_in), .rd_pulse(rd_pulse),
        .M_AXI_GP0_0_araddr(araddr), .M_AXI_GP0_0_arburst(arburst),
        .M_AXI_GP0_0_arlen(arlen), .M_AXI_GP0_0_arsize(3'b010),
        .M_AXI_GP0_0_arid(arid), .M_AXI_GP0_0_arcache(4'h3),
        .M_AXI_GP0_0_arlock(2'b00), .M_AXI_GP0_0_arprot(3'b000),
        .M_AXI_GP0_0_arqos(4'h0), .M_AXI_GP0_0_arvalid(arvalid),
        .M_AXI_GP0_0_arready(arready), .M_AXI_GP0_0_rdata(rdata),
        .M_AXI_GP0_0_rid(rid), .M_AXI_GP0_0_rresp(rresp),
        .M_AXI_GP0_0_rlast(rlast), .M_AXI_GP0_0_rvalid(rvalid),
        .M_AXI_GP0_0_rready(rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        if (i < 0 || i >= 64) return 32'd0;
        if (i == 2) return 32'hDEAD_BEEF;
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Entered and left at posedge+1. stall bit c = rready low in cycle c of the R phase.
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] bt,
                             input logic [11:0] id, input logic [31:0] stall);
        int idx, beat, cyc;
        logic [63:0] ep;
        logic inr;
        araddr = addr; arlen = len; arburst = bt; arid = id; arvalid = 1'b1; rready = 1'b0;
        #1 chk("ar_ready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        idx = int'((addr - BASE) >> 2);
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 64) begin
            rready = !stall[cyc % 32];
            inr = (idx >= 0 && idx < 64);
            ep = (rready && inr) ? (64'd1 << idx) : 64'd0;
            #1;
            chk("rvalid", 64'(rvalid), 64'd1);
            chk("rdata", 64'(rdata), 64'(model_word(idx)));
            chk("rid", 64'(rid), 64'(id));
            chk("rlast", 64'(rlast), 64'(beat == int'(len)));
            chk("rresp", 64'(rresp), 64'(inr ? 2'b00 : OOR));
            chk("rd_pulse", rd_pulse, ep);
            if (rd_pulse[4]) pulse4_seen++;
            @(posedge clk); #1;
            if (rready) begin
                beat++;
                if (bt != 2'b00) idx++;
            end
            cyc++;
        end
        chk("burst_done", 64'(cyc < 64), 64'd1);
        rready = 1'b0;
        #1;
        chk("idle_rvalid", 64'(rvalid), 64'd0);
        chk("idle_arready", 64'(arready), 64'd1);
        chk("idle_pulse", rd_pulse, 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [63:0] exp_pulse;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{BASE + 32'h08,  32'hDEAD_BEEF, 2'b00, 64'h4};
        vecs[1] = '{BASE + 32'h00,  32'hA500_0000, 2'b00, 64'h1};
        vecs[2] = '{BASE + 32'hFC,  32'hA500_003F, 2'b00, 64'h8000_0000_0000_0000};
        vecs[3] = '{BASE + 32'h0B,  32'hDEAD_BEEF, 2'b00, 64'h4};
        vecs[4] = '{BASE + 32'h100, 32'h0,         OOR,   64'h0};
        vecs[5] = '{BASE - 32'h4,   32'h0,         OOR,   64'h0};

        for (int i = 0; i < 64; i++) reg_in[32*i +: 32] = model_word(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_pulse", rd_pulse, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_arready", 64'(arready), 64'd1);

        // Table-driven single-beat reads with hand-computed results
        for (int v = 0; v < 6; v++) begin
            araddr = vecs[v].addr; arlen = 4'd0; arburst = 2'b01; arid = 12'(v);
            arvalid = 1'b1; rready = 1'b1;
            @(posedge clk); #1;
            arvalid = 1'b0;
            #1;
            chk("t_rvalid", 64'(rvalid), 64'd1);
            chk("t_rdata", 64'(rdata), 64'(vecs[v].exp_data));
            chk("t_rresp", 64'(rresp), 64'(vecs[v].exp_resp));
            chk("t_rlast", 64'(rlast), 64'd1);
            chk("t_rid", 64'(rid), 64'(v));
            chk("t_pulse", rd_pulse, vecs[v].exp_pulse);
            @(posedge clk); #1;
            chk("t_arready", 64'(arready), 64'd1);
            chk("t_rvalid_off", 64'(rvalid), 64'd0);
            chk("t_pulse_off", rd_pulse, 64'd0);
            rready = 1'b0;
        end

        // INCR words 3..6
        run_burst(BASE + 32'h0C, 4'd3, 2'b01, 12'h5A5, 32'h0);
        // FIXED word 4, rready 1,0,1,0,1
        pulse4_seen = 0;
        run_burst(BASE + 32'h10, 4'd2, 2'b00, 12'h011, 32'b01010);
        chk("fixed_pulse_count", 64'(pulse4_seen), 64'd3);
        // Off the end of the bank: 62, 63, then two out-of-range beats
        run_burst(BASE + 32'hF8, 4'd3, 2'b01, 12'h0F8, 32'h0);
        // WRAP handled as INCR
        run_burst(BASE + 32'h20, 4'd1, 2'b10, 12'h222, 32'h0);
        // Full 16-beat burst with a couple of stalls
        run_burst(BASE + 32'h00, 4'd15, 2'b01, 12'hFFF, 32'b1000_0100);

        // Data held while stalled even when reg_in changes; next beat picks up the new value
        araddr = BASE + 32'h14; arlen = 4'd1; arburst = 2'b00; arid = 12'h033; arvalid = 1'b1;
        rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        reg_in[32*5 +: 32] = 32'h1234_5678;
        @(posedge clk); #1;
        chk("hold_rdata", 64'(rdata), 64'hA500_0005);
        rready = 1'b1;
        @(posedge clk); #1;
        chk("reload_rdata", 64'(rdata), 64'h1234_5678);
        chk("reload_rlast", 64'(rlast), 64'd1);
        @(posedge clk); #1;
        rready = 1'b0;
        reg_in[32*5 +: 32] = model_word(5);

        // Reset mid-burst
        araddr = BASE; arlen = 4'd7; arburst = 2'b01; arid = 12'h077; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rdata", 64'(rdata), 64'(model_word(2)));
        rready = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rvalid", 64'(rvalid), 64'd0);
        chk("mid_pulse", rd_pulse, 64'd0);
        chk("mid_arready", 64'(arready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_burst(BASE + 32'h08, 4'd0, 2'b01, 12'h123, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
